// File: rtl/fetch_prefetch_buffer_pkg.sv
// Shared constants and types for the instruction-fetch prefetch buffer.
// Covers the datapath width, the NOP filler, the PC step and the FIFO entry layout.
package fetch_prefetch_buffer_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // RUN forwards responses; DRAIN discards responses issued before a redirect
    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_prefetch_buffer_if.sv
// Bundles the redirect, memory and decode handshakes of the fetch front end.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_prefetch_buffer_if
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            mem_req_valid;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_ready;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_data;
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_instr;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_ready;
    logic [CW-1:0]   buffer_count;

    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, fetch_ready,
        output mem_req_valid, mem_req_addr, fetch_valid, fetch_instr, fetch_pc, buffer_count
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, fetch_ready,
        input  mem_req_valid, mem_req_addr, fetch_valid, fetch_instr, fetch_pc, buffer_count
    );

endinterface

// File: rtl/fetch_prefetch_buffer_fifo.sv
// Synchronous FIFO of {pc, instr} entries with flush and an occupancy count.
// Storage is not reset; only the pointers and count are.
module fetch_prefetch_buffer_fifo
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

    push_into_full: assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && count == CW'(DEPTH)));

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// In-order instruction prefetcher: issues word fetches under a credit limit,
// buffers responses with their PCs and drops stale responses after a redirect.
module fetch_prefetch_buffer
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic clk,
    input  logic reset,
    fetch_prefetch_buffer_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] next_pc_q, next_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_sum;
    logic            req_valid, req_fire, push, pop, fetch_valid;
    fetch_state_e    state;
    fetch_entry_t    head;
    fetch_entry_t    wdata;

    // Buffered plus in-flight entries may never exceed the FIFO size
    assign credit_sum = {1'b0, count} + {1'b0, outstanding_q};
    assign req_valid  = !reset && (credit_sum < (CW+1)'(DEPTH));
    assign req_fire   = req_valid && bus.mem_req_ready;
    assign state      = (drop_cnt_q != '0) ? ST_DRAIN : ST_RUN;
    assign fetch_valid = (count != '0);
    assign wdata      = '{pc: resp_pc_q, instr: bus.mem_resp_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_pc_q     <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            next_pc_q     <= next_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    always_comb begin
        next_pc_d     = next_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        push          = 1'b0;
        pop           = fetch_valid && bus.fetch_ready;
        if (req_fire) begin
            next_pc_d     = next_pc_q + PC_INC;
            outstanding_d = outstanding_d + CW'(1);
        end
        if (bus.mem_resp_valid && outstanding_q != '0) outstanding_d = outstanding_d - CW'(1);
        unique case (state)
            ST_DRAIN: if (bus.mem_resp_valid) drop_cnt_d = drop_cnt_q - CW'(1);
            default: begin
                push = bus.mem_resp_valid;
                if (push) resp_pc_d = resp_pc_q + PC_INC;
            end
        endcase
        // Redirect wins: everything requested so far, including this cycle, becomes stale
        if (bus.redirect_valid) begin
            next_pc_d  = align_pc(bus.redirect_pc);
            resp_pc_d  = align_pc(bus.redirect_pc);
            drop_cnt_d = outstanding_d;
            push       = 1'b0;
            pop        = 1'b0;
        end
    end

    fetch_prefetch_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .wdata (wdata),
        .rdata (head),
        .count (count)
    );

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = next_pc_q;
    assign bus.fetch_valid   = fetch_valid;
    assign bus.fetch_instr   = fetch_valid ? head.instr : NOP_INSTR;
    assign bus.fetch_pc      = fetch_valid ? head.pc : '0;
    assign bus.buffer_count  = count;

    resp_without_request: assert property (@(posedge clk) disable iff (reset)
        !(bus.mem_resp_valid && outstanding_q == '0));

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for the prefetch buffer with a variable-latency memory model
// and a scoreboard of expected {pc, instr} entries.
module tb_fetch_prefetch_buffer;
    import fetch_prefetch_buffer_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          gen;
    } mem_req_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    fetch_prefetch_buffer_if #(.DEPTH(DEPTH)) bus ();

    fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mem_req_t     mem_q[$];
    fetch_entry_t sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           gen = 0;
    int           latency = 1;
    logic         mem_ready_en = 1'b0;
    logic         fetch_ready_en = 1'b0;
    logic [31:0]  exp_next = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance the model
    task automatic apply_stimulus(input logic redir, input logic [31:0] target);
        logic     resp;
        mem_req_t r;
        @(negedge clk);
        cyc++;
        check_output("count", 32'(bus.buffer_count), 32'(sb.size()));
        check_output("fetch_valid", 32'(bus.fetch_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check_output("fetch_pc", bus.fetch_pc, sb[0].pc);
            check_output("fetch_instr", bus.fetch_instr, sb[0].instr);
        end else begin
            check_output("empty_pc", bus.fetch_pc, 32'h0);
            check_output("empty_instr", bus.fetch_instr, NOP_INSTR);
        end
        check_output("req_valid", 32'(bus.mem_req_valid), 32'((sb.size() + mem_q.size()) < DEPTH));

        resp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        bus.mem_req_ready  = mem_ready_en;
        bus.fetch_ready    = fetch_ready_en;
        bus.redirect_valid = redir;
        bus.redirect_pc    = target;
        bus.mem_resp_valid = resp;
        bus.mem_resp_data  = resp ? instr_of(mem_q[0].addr) : 32'hDEAD_BEEF;

        if (bus.mem_req_valid && mem_ready_en) begin
            check_output("req_addr", bus.mem_req_addr, exp_next);
            mem_q.push_back('{exp_next, cyc + latency, gen});
            exp_next = exp_next + 32'd4;
        end
        if (bus.fetch_valid && fetch_ready_en && sb.size() != 0) void'(sb.pop_front());
        if (resp) begin
            r = mem_q.pop_front();
            if (!redir && r.gen == gen) sb.push_back('{pc: r.addr, instr: instr_of(r.addr)});
        end
        if (redir) begin
            sb.delete();
            gen++;
            exp_next = {target[31:2], 2'b00};
        end
    endtask

    // Assert reset between edges and confirm outputs clear without a clock edge
    task automatic do_reset(input int hold);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_output("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
        check_output("rst_req_addr", bus.mem_req_addr, 32'h0);
        check_output("rst_fetch_valid", 32'(bus.fetch_valid), 32'h0);
        check_output("rst_fetch_instr", bus.fetch_instr, NOP_INSTR);
        check_output("rst_fetch_pc", bus.fetch_pc, 32'h0);
        check_output("rst_count", 32'(bus.buffer_count), 32'h0);
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;
        bus.fetch_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_q.delete();
        sb.delete();
        gen++;
        exp_next = 32'h0;
    endtask

    task automatic drain();
        mem_ready_en   = 1'b0;
        fetch_ready_en = 1'b1;
        repeat (10) apply_stimulus(1'b0, 32'h0);
    endtask

    initial begin
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;
        bus.fetch_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        do_reset(2);

        $display("[TB] streaming with 1-cycle memory");
        latency = 1;
        mem_ready_en = 1'b1;
        fetch_ready_en = 1'b1;
        repeat (20) apply_stimulus(1'b0, 32'h0);

        $display("[TB] decode stalled, buffer fills");
        fetch_ready_en = 1'b0;
        repeat (10) apply_stimulus(1'b0, 32'h0);
        check_output("full_count", 32'(bus.buffer_count), 32'd4);
        check_output("full_req_valid", 32'(bus.mem_req_valid), 32'h0);
        fetch_ready_en = 1'b1;
        apply_stimulus(1'b0, 32'h0);
        fetch_ready_en = 1'b0;
        repeat (4) apply_stimulus(1'b0, 32'h0);

        $display("[TB] redirect with two slow requests in flight");
        drain();
        latency = 3;
        mem_ready_en = 1'b1;
        repeat (2) apply_stimulus(1'b0, 32'h0);
        mem_ready_en = 1'b0;
        apply_stimulus(1'b1, 32'h0000_0103);
        mem_ready_en = 1'b1;
        apply_stimulus(1'b0, 32'h0);
        check_output("redir_addr", bus.mem_req_addr, 32'h0000_0100);
        repeat (12) apply_stimulus(1'b0, 32'h0);

        $display("[TB] redirect colliding with request and response");
        drain();
        apply_stimulus(1'b1, 32'h0000_0008);
        latency = 2;
        mem_ready_en = 1'b1;
        repeat (2) apply_stimulus(1'b0, 32'h0);
        apply_stimulus(1'b1, 32'h0000_0200);
        check_output("collide_addr", bus.mem_req_addr, 32'h0000_0010);
        apply_stimulus(1'b0, 32'h0);
        check_output("collide_empty", 32'(bus.buffer_count), 32'h0);
        repeat (10) apply_stimulus(1'b0, 32'h0);

        $display("[TB] address wrap");
        drain();
        apply_stimulus(1'b1, 32'hFFFF_FFFC);
        latency = 1;
        mem_ready_en = 1'b1;
        apply_stimulus(1'b0, 32'h0);
        check_output("wrap_first", bus.mem_req_addr, 32'hFFFF_FFFC);
        apply_stimulus(1'b0, 32'h0);
        check_output("wrap_second", bus.mem_req_addr, 32'h0000_0000);
        repeat (8) apply_stimulus(1'b0, 32'h0);

        $display("[TB] reset mid-stream");
        latency = 2;
        fetch_ready_en = 1'b0;
        repeat (4) apply_stimulus(1'b0, 32'h0);
        do_reset(2);
        latency = 1;
        mem_ready_en = 1'b1;
        fetch_ready_en = 1'b1;
        apply_stimulus(1'b0, 32'h0);
        check_output("post_rst_addr", bus.mem_req_addr, 32'h0);
        repeat (10) apply_stimulus(1'b0, 32'h0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
